rv32i_processor: RTL and testbench
==================================

Name: rv32i_processor

Overview:
- Single-cycle RV32I-subset core with instruction memory, register file and data memory built in; one instruction retires per clock.
- Top-level CPU block under the lab testbench.
- The bench preloads all three memories hierarchically before reset deasserts.
- The bench dumps the register file and data memory at end of simulation.

Parameters:
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words.
- DMEM_DEPTH, 256, data memory depth in 32-bit words.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.

Behaviour:
- Required instance and array names, used for hierarchical preload and dump:
  - inst_mem_i.mem: IMEM_DEPTH x 32.
  - reg_file_i.reg_mem: 32 x 32.
  - data_mem_i.data_mem: DMEM_DEPTH x 32.
  - Each array is indexed from 0 and holds binary-loadable 32-bit words.
- Reset:
  - rst low forces PC=0 immediately, with no clock needed, and holds it there.
  - While rst is low, no register-file or data-memory writes occur.
  - Reset does not clear reg_mem, data_mem or mem, so preloaded contents survive.
  - After rst rises, the first rising edge executes mem[0].
- Fetch: instr = mem[PC[log2(IMEM_DEPTH)+1:2]]. PC[1:0] is ignored. The index wraps modulo IMEM_DEPTH. Fetch is combinational.
- Register file:
  - Two combinational read ports, one write port on the rising edge.
  - x0 reads 0 always; writes to x0 are discarded.
  - A read of the register being written this cycle returns the old value.
- Supported instructions (single cycle, PC updates every edge):
  - R-type (0110011): add, sub, sll, slt, sltu, xor, srl, sra, or, and.
  - I-type ALU (0010011): addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
  - lw (0000011, funct3=010): rd = data_mem[(rs1+imm)[log2(DMEM_DEPTH)+1:2]]. Read is combinational.
  - sw (0100011, funct3=010): data_mem[index] = rs2, written on the rising edge.
  - Branches (1100011): beq, bne, blt, bge, bltu, bgeu. Taken: PC = PC + B-imm. Not taken: PC = PC + 4.
  - jal: rd = PC+4, PC = PC + J-imm.
  - jalr: rd = PC+4, PC = (rs1 + imm) & ~1.
  - lui: rd = U-imm.
  - auipc: rd = PC + U-imm.
- Arithmetic:
  - 32-bit wraparound, no overflow traps.
  - Shift amount is the low 5 bits of the operand.
  - Immediates are sign-extended per the RV32I formats.
  - Data addresses ignore bits [1:0] and wrap modulo DMEM_DEPTH.
- Unsupported opcodes and load/store with funct3 != 010 behave as NOP: PC += 4, no writes.
- Reset mid-run: PC snaps to 0 asynchronously. No write commits on an edge where rst is low.

Decomposition:
- Shared package rv32_pkg:
  - opcode constants.
  - funct3/funct7 constants.
  - alu_op_e enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B).
  - imm-type enum.
- Required sub-instances: inst_mem_i, reg_file_i, data_mem_i.
- One natural extra sub-module: alu, purely combinational over alu_op_e.
- Decoder and immediate generation stay inline.

Test Plan:
- add: mem[0]=0x002201B3 (add x3,x4,x2), x2=5, x4=7 → after the first post-reset edge x3=12 and PC=4.
- x0 protection: addi x0,x0,5 → x0 still reads 0. sub x5,x0,x1 with x1=1 → x5=0xFFFFFFFF.
- Store/load: x1=8, x2=0xDEADBEEF; sw x2,4(x1) then lw x3,4(x1) → data_mem[3]=0xDEADBEEF, x3=0xDEADBEEF.
- Branches: x1=x2=3; beq x1,x2,+8 at PC=0 → next PC=8. bne at the same point → next PC=4.
- Jumps: jal x1,+16 at PC=4 → x1=8, PC=20. jalr x0,0(x1) → PC=8.
- Reset: preload rf and dm, run 3 instructions, then pulse rst low mid-cycle → PC=0 immediately, preloaded and written contents retained, execution restarts from mem[0].

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared definitions for the single-cycle RV32I core: opcodes, function
// codes, ALU operation and immediate-format enums.
package rv32_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASS_B
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef enum logic [1:0] {
    WB_ALU,
    WB_MEM,
    WB_PC4
  } wb_sel_e;

  // Map funct3 (plus the funct7[5] "alternate" bit) onto an ALU operation.
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_processor_alu.sv
// Purely combinational 32-bit ALU; shifts use the low 5 bits of b.
module rv32i_processor_alu
  import rv32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     op,
  output logic [31:0] y
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // Operation select
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << shamt;
      ALU_SLT:    y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:   y = {31'b0, a < b};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> shamt;
      ALU_SRA:    y = $signed(a) >>> shamt;
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_PASS_B: y = b;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_processor_data_mem.sv
// Word-addressed data memory: combinational read, write on the rising edge.
module rv32i_processor_data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] data_mem [DEPTH];

  assign rdata = data_mem[addr];

  // Store port
  always_ff @(posedge clk) begin
    if (we) data_mem[addr] <= wdata;
  end

endmodule

// File: rtl/rv32i_processor_inst_mem.sv
// Instruction memory: combinational read, optional synchronous load port
// (tied off in the core; contents normally preloaded from outside).
module rv32i_processor_inst_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Program load port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rv32i_processor_reg_file.sv
// 32 x 32 register file: two combinational read ports, one write port.
// x0 always reads zero and ignores writes; a read during a write sees the old value.
module rv32i_processor_reg_file (
  input  logic        clk,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] reg_mem [32];

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : reg_mem[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : reg_mem[ra2];

  // Register write, x0 discarded
  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) reg_mem[wa] <= wd;
  end

endmodule

// File: rtl/rv32i_processor.sv
// Single-cycle RV32I-subset core. One instruction retires per rising edge;
// rst (active low) snaps the PC to zero and blocks all register/memory writes.
module rv32i_processor
  import rv32_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input logic clk,
  input logic rst
);

  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  logic [31:0] pc, pc_next, pc_plus4;
  logic [31:0] instr, imm;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] alu_a, alu_b, alu_y;
  logic [31:0] dm_rdata, wb_data;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;

  imm_type_e imm_type;
  alu_op_e   alu_op;
  wb_sel_e   wb_sel;
  logic      alu_a_pc, alu_b_imm;
  logic      rf_we_dec, dm_we_dec;
  logic      is_branch, is_jal, is_jalr, br_taken;

  // Program counter, asynchronously forced to zero while rst is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else      pc <= pc_next;
  end

  assign pc_plus4 = pc + 32'd4;

  rv32i_processor_inst_mem #(.DEPTH(IMEM_DEPTH)) inst_mem_i (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .raddr (pc[IMEM_AW+1:2]),
    .rdata (instr)
  );

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  // Instruction decode; anything not recognised falls through as a NOP
  always_comb begin
    imm_type  = IMM_I;
    alu_op    = ALU_ADD;
    wb_sel    = WB_ALU;
    alu_a_pc  = 1'b0;
    alu_b_imm = 1'b0;
    rf_we_dec = 1'b0;
    dm_we_dec = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == F7_BASE ||
            (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA))) begin
          alu_op    = alu_op_from_f3(funct3, funct7[5]);
          rf_we_dec = 1'b1;
        end
      end
      OP_I: begin
        // Shift-immediates reuse imm[11:5] as funct7; other encodings there are illegal
        if ((funct3 != F3_SLL && funct3 != F3_SRL_SRA) || funct7 == F7_BASE ||
            (funct3 == F3_SRL_SRA && funct7 == F7_ALT)) begin
          alu_op    = alu_op_from_f3(funct3, (funct3 == F3_SRL_SRA) && funct7[5]);
          alu_b_imm = 1'b1;
          rf_we_dec = 1'b1;
        end
      end
      OP_LOAD: begin
        if (funct3 == F3_WORD) begin
          alu_b_imm = 1'b1;
          wb_sel    = WB_MEM;
          rf_we_dec = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3 == F3_WORD) begin
          imm_type  = IMM_S;
          alu_b_imm = 1'b1;
          dm_we_dec = 1'b1;
        end
      end
      OP_BRANCH: begin
        imm_type  = IMM_B;
        is_branch = 1'b1;
      end
      OP_JAL: begin
        imm_type  = IMM_J;
        is_jal    = 1'b1;
        wb_sel    = WB_PC4;
        rf_we_dec = 1'b1;
      end
      OP_JALR: begin
        if (funct3 == F3_JALR) begin
          alu_b_imm = 1'b1;
          is_jalr   = 1'b1;
          wb_sel    = WB_PC4;
          rf_we_dec = 1'b1;
        end
      end
      OP_LUI: begin
        imm_type  = IMM_U;
        alu_op    = ALU_PASS_B;
        alu_b_imm = 1'b1;
        rf_we_dec = 1'b1;
      end
      OP_AUIPC: begin
        imm_type  = IMM_U;
        alu_a_pc  = 1'b1;
        alu_b_imm = 1'b1;
        rf_we_dec = 1'b1;
      end
      default: ;
    endcase
  end

  // Sign-extended immediate for the decoded format
  always_comb begin
    imm = {{20{instr[31]}}, instr[31:20]};
    case (imm_type)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  rv32i_processor_reg_file reg_file_i (
    .clk (clk),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rs1_data),
    .rd2 (rs2_data),
    .we  (rf_we_dec & rst),
    .wa  (rd),
    .wd  (wb_data)
  );

  assign alu_a = alu_a_pc  ? pc  : rs1_data;
  assign alu_b = alu_b_imm ? imm : rs2_data;

  rv32i_processor_alu alu_i (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  // Branch condition on the two register operands
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1_data == rs2_data);
      F3_BNE:  br_taken = (rs1_data != rs2_data);
      F3_BLT:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
      F3_BGE:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: br_taken = (rs1_data <  rs2_data);
      F3_BGEU: br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  rv32i_processor_data_mem #(.DEPTH(DMEM_DEPTH)) data_mem_i (
    .clk   (clk),
    .addr  (alu_y[DMEM_AW+1:2]),
    .we    (dm_we_dec & rst),
    .wdata (rs2_data),
    .rdata (dm_rdata)
  );

  // Register write-back source
  always_comb begin
    wb_data = alu_y;
    case (wb_sel)
      WB_MEM:  wb_data = dm_rdata;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_y;
    endcase
  end

  // Next PC: jal / taken branch are PC-relative, jalr uses the ALU sum with bit 0 cleared
  always_comb begin
    pc_next = pc_plus4;
    if (is_jal || (is_branch && br_taken)) pc_next = pc + imm;
    else if (is_jalr)                      pc_next = {alu_y[31:1], 1'b0};
  end

endmodule

// File: tb/tb_rv32i_processor.sv
// Directed and randomized checks of the single-cycle core against an
// instruction-level reference model kept in the bench.
module tb_rv32i_processor;

  localparam int IMEM_DEPTH = 256;
  localparam int DMEM_DEPTH = 256;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] m_imem [IMEM_DEPTH];
  logic [31:0] m_rf   [32];
  logic [31:0] m_dm   [DMEM_DEPTH];
  logic [31:0] m_pc;

  rv32i_processor #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic int word_idx(input logic [31:0] addr, input int depth);
    return int'((addr >> 2) % 32'(depth));
  endfunction

  // Reference ALU from the ISA definitions (alt = instruction bit 30)
  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    case (f3)
      3'd0:    r = alt ? x - y : x + y;
      3'd1:    r = x << y[4:0];
      3'd2:    r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3:    r = (x < y) ? 32'd1 : 32'd0;
      3'd4:    r = x ^ y;
      3'd5:    r = alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6:    r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  // Execute one instruction on the model state
  task automatic model_step();
    logic [31:0] ins, a, b, ii, is, ib, iu, ij, nxt, val;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        wr, take;
    ins  = m_imem[word_idx(m_pc, IMEM_DEPTH)];
    rd   = ins[11:7];
    f3   = ins[14:12];
    f7   = ins[31:25];
    a    = (ins[19:15] == 5'd0) ? 32'd0 : m_rf[ins[19:15]];
    b    = (ins[24:20] == 5'd0) ? 32'd0 : m_rf[ins[24:20]];
    ii   = {{20{ins[31]}}, ins[31:20]};
    is   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    iu   = {ins[31:12], 12'h000};
    ij   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    nxt  = m_pc + 32'd4;
    val  = '0;
    wr   = 1'b0;
    take = 1'b0;
    case (ins[6:0])
      7'h33: begin
        wr  = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        val = ref_alu(f3, f7[5], a, b);
      end
      7'h13: begin
        if (f3 == 3'd1)      wr = (f7 == 7'h00);
        else if (f3 == 3'd5) wr = (f7 == 7'h00 || f7 == 7'h20);
        else                 wr = 1'b1;
        val = ref_alu(f3, (f3 == 3'd5) && f7[5], a, ii);
      end
      7'h03: begin
        wr  = (f3 == 3'd2);
        val = m_dm[word_idx(a + ii, DMEM_DEPTH)];
      end
      7'h23: if (f3 == 3'd2) m_dm[word_idx(a + is, DMEM_DEPTH)] = b;
      7'h63: begin
        case (f3)
          3'd0:    take = (a == b);
          3'd1:    take = (a != b);
          3'd4:    take = ($signed(a) <  $signed(b));
          3'd5:    take = ($signed(a) >= $signed(b));
          3'd6:    take = (a <  b);
          3'd7:    take = (a >= b);
          default: take = 1'b0;
        endcase
        if (take) nxt = m_pc + ib;
      end
      7'h6f: begin
        wr  = 1'b1;
        val = m_pc + 32'd4;
        nxt = m_pc + ij;
      end
      7'h67: if (f3 == 3'd0) begin
        wr  = 1'b1;
        val = m_pc + 32'd4;
        nxt = (a + ii) & ~32'd1;
      end
      7'h37: begin wr = 1'b1; val = iu; end
      7'h17: begin wr = 1'b1; val = m_pc + iu; end
      default: ;
    endcase
    if (wr && rd != 5'd0) m_rf[rd] = val;
    m_pc = nxt;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r, r2, res;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm12;
    r     = $urandom;
    r2    = $urandom;
    rd    = r[4:0];
    rs1   = r[9:5];
    rs2   = r[14:10];
    f3    = r[17:15];
    imm12 = r2[11:0];
    case ($urandom_range(0, 11))
      0, 1: begin
        f7  = ((f3 == 3'd0 || f3 == 3'd5) && r[31]) ? 7'h20 : 7'h00;
        res = enc_r(f7, rs2, rs1, f3, rd);
      end
      2, 3: begin
        if (f3 == 3'd1)      imm12 = {7'h00, imm12[4:0]};
        else if (f3 == 3'd5) imm12 = {(r[31] ? 7'h20 : 7'h00), imm12[4:0]};
        res = enc_i(imm12, rs1, f3, rd, 7'h13);
      end
      4:       res = enc_i(imm12, rs1, r[30] ? 3'd2 : f3, rd, 7'h03);
      5:       res = enc_s(imm12, rs2, rs1, r[30] ? 3'd2 : f3);
      6, 7:    res = enc_b({r2[23:12], 1'b0}, rs2, rs1, f3);
      8:       res = enc_j({r2[31:12], 1'b0}, rd);
      9:       res = enc_i(imm12, rs1, r[30] ? 3'd0 : f3, rd, 7'h67);
      10:      res = {r2[31:12], rd, (r[31] ? 7'h37 : 7'h17)};
      default: res = {r2[31:7], (r[31] ? 7'h0F : 7'h73)};
    endcase
    return res;
  endfunction

  task automatic put_imem(input int i, input logic [31:0] v);
    m_imem[i] = v;
    dut.inst_mem_i.mem[i] = v;
  endtask

  task automatic put_rf(input int i, input logic [31:0] v);
    m_rf[i] = v;
    dut.reg_file_i.reg_mem[i] = v;
  endtask

  task automatic put_dm(input int i, input logic [31:0] v);
    m_dm[i] = v;
    dut.data_mem_i.data_mem[i] = v;
  endtask

  task automatic clear_all();
    for (int i = 0; i < IMEM_DEPTH; i++) put_imem(i, NOP);
    for (int i = 0; i < 32; i++)         put_rf(i, 32'd0);
    for (int i = 0; i < DMEM_DEPTH; i++) put_dm(i, 32'd0);
  endtask

  task automatic enter_reset();
    rst = 1'b0;
    #1;
  endtask

  task automatic leave_reset();
    @(negedge clk);
    rst  = 1'b1;
    m_pc = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  initial begin
    // Power-on reset: PC is zero before any clock edge and stays there
    #1;
    rst = 1'b0;
    #1;
    check("reset_pc_async", dut.pc, 32'd0);
    clear_all();
    @(posedge clk);
    #1;
    check("reset_pc_hold", dut.pc, 32'd0);

    // add x3,x4,x2
    put_imem(0, 32'h002201B3);
    put_rf(2, 32'd5);
    put_rf(4, 32'd7);
    leave_reset();
    step();
    check("add_x3", dut.reg_file_i.reg_mem[3], 32'd12);
    check("add_pc", dut.pc, 32'd4);

    // x0 protection, then sub from x0
    #2;
    enter_reset();
    check("reset_pc_snap", dut.pc, 32'd0);
    clear_all();
    put_imem(0, enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13));
    put_imem(1, enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd5));
    put_imem(2, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd6));
    put_rf(1, 32'd1);
    put_rf(6, 32'h77);
    leave_reset();
    step();
    step();
    check("sub_x5", dut.reg_file_i.reg_mem[5], 32'hFFFF_FFFF);
    step();
    check("x0_reads_zero", dut.reg_file_i.reg_mem[6], 32'd0);

    // sw x2,4(x1) ; lw x3,4(x1)
    enter_reset();
    clear_all();
    put_imem(0, enc_s(12'd4, 5'd2, 5'd1, 3'd2));
    put_imem(1, enc_i(12'd4, 5'd1, 3'd2, 5'd3, 7'h03));
    put_rf(1, 32'd8);
    put_rf(2, 32'hDEAD_BEEF);
    leave_reset();
    step();
    check("sw_dm3", dut.data_mem_i.data_mem[3], 32'hDEAD_BEEF);
    step();
    check("lw_x3", dut.reg_file_i.reg_mem[3], 32'hDEAD_BEEF);

    // beq taken
    enter_reset();
    clear_all();
    put_imem(0, enc_b(13'd8, 5'd2, 5'd1, 3'd0));
    put_rf(1, 32'd3);
    put_rf(2, 32'd3);
    leave_reset();
    step();
    check("beq_pc", dut.pc, 32'd8);

    // bne not taken
    enter_reset();
    put_imem(0, enc_b(13'd8, 5'd2, 5'd1, 3'd1));
    leave_reset();
    step();
    check("bne_pc", dut.pc, 32'd4);

    // jal x1,+16 at PC=4 ; jalr x0,0(x1) at PC=20
    enter_reset();
    clear_all();
    put_imem(1, enc_j(21'd16, 5'd1));
    put_imem(5, enc_i(12'd0, 5'd1, 3'd0, 5'd0, 7'h67));
    leave_reset();
    step();
    step();
    check("jal_x1", dut.reg_file_i.reg_mem[1], 32'd8);
    check("jal_pc", dut.pc, 32'd20);
    step();
    check("jalr_pc", dut.pc, 32'd8);

    // Mid-run reset keeps preloaded and written state, restarts at mem[0]
    enter_reset();
    clear_all();
    put_imem(0, enc_i(12'd1, 5'd5, 3'd0, 5'd5, 7'h13));
    put_imem(1, enc_s(12'd8, 5'd5, 5'd0, 3'd2));
    put_imem(2, enc_i(12'd2, 5'd6, 3'd0, 5'd6, 7'h13));
    put_rf(5, 32'd100);
    put_rf(6, 32'd200);
    put_rf(9, 32'h55);
    put_dm(7, 32'hCAFE_F00D);
    leave_reset();
    step();
    step();
    step();
    check("midrun_pc_before", dut.pc, 32'd12);
    #3;
    rst = 1'b0;
    #1;
    check("midrun_pc_snap", dut.pc, 32'd0);
    check("midrun_x5", dut.reg_file_i.reg_mem[5], 32'd101);
    check("midrun_x6", dut.reg_file_i.reg_mem[6], 32'd202);
    check("midrun_x9", dut.reg_file_i.reg_mem[9], 32'h55);
    check("midrun_dm2", dut.data_mem_i.data_mem[2], 32'd101);
    check("midrun_dm7", dut.data_mem_i.data_mem[7], 32'hCAFE_F00D);
    @(posedge clk);
    #1;
    check("reset_no_write_x5", dut.reg_file_i.reg_mem[5], 32'd101);
    check("reset_hold_pc2", dut.pc, 32'd0);
    leave_reset();
    step();
    check("restart_x5", dut.reg_file_i.reg_mem[5], 32'd102);
    check("restart_pc", dut.pc, 32'd4);

    // Random program against the reference model
    enter_reset();
    for (int i = 0; i < IMEM_DEPTH; i++) put_imem(i, rand_instr());
    put_rf(0, 32'd0);
    for (int i = 1; i < 32; i++)         put_rf(i, $urandom);
    for (int i = 0; i < DMEM_DEPTH; i++) put_dm(i, $urandom);
    leave_reset();
    for (int n = 0; n < 400; n++) begin
      step();
      check($sformatf("rand_pc_%0d", n), dut.pc, m_pc);
      if (n % 50 == 49) begin
        for (int r = 1; r < 32; r++)
          check($sformatf("rand_x%0d_at_%0d", r, n), dut.reg_file_i.reg_mem[r], m_rf[r]);
      end
    end
    for (int i = 0; i < DMEM_DEPTH; i++)
      check($sformatf("rand_dm_%0d", i), dut.data_mem_i.data_mem[i], m_dm[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
